// File: rtl/serout_shifter.sv
// serout_shifter: serial-output holding register plus 10-bit frame shifter.
//
// A CPU write lands in a one-deep holding register. On a bit_tick the held byte
// moves into the shifter as {stop=1, data, start=0} and goes out LSB first, one
// bit per bit_tick. If a new byte is already held when the stop bit ends, it is
// loaded on that same tick, so there is no idle gap between frames.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   wr_serout    one-cycle CPU write strobe
//   din[7:0]     write data
//   bit_tick     one pulse per bit period
//   force_break  forces the line low while high; shifting is not affected
//   tone1/tone2/two_tone  tone inputs, present only with SEROUT_TWO_TONE_EN
//   sdo          registered serial line, idles high
//   seror_irq    one-cycle pulse on the cycle after each holding->shifter transfer
//   seroc        registered "transmission complete": idle and nothing held
//   busy         high while a frame is being shifted
//
// Build option: define SEROUT_TWO_TONE_EN to add the two-tone line encoding.
module serout_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_serout,
    input  logic [7:0] din,
    input  logic       bit_tick,
    input  logic       force_break,
`ifdef SEROUT_TWO_TONE_EN
    input  logic       tone1,
    input  logic       tone2,
    input  logic       two_tone,
`endif
    output logic       sdo,
    output logic       seror_irq,
    output logic       seroc,
    output logic       busy
);

    typedef enum logic {IDLE, SHIFT} stateT;

    stateT       state, stateNext;
    logic [7:0]  holdData, holdDataNext;
    logic        holdFull, holdFullNext;
    logic [9:0]  shiftReg, shiftNext;   // bit 0 is the bit currently on the line
    logic [3:0]  bitCnt, bitCntNext;    // index of the bit on the line, 0..9
    logic        xfer;                  // holding register moves to the shifter
    logic        lineBit;               // raw frame bit for the next cycle
    logic        lineNext;              // encoded line level for the next cycle

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            holdData  <= 8'h00;
            holdFull  <= 1'b0;
            shiftReg  <= 10'h3FF;
            bitCnt    <= 4'd0;
            sdo       <= 1'b1;
            seror_irq <= 1'b0;
            seroc     <= 1'b1;
        end else begin
            state     <= stateNext;
            holdData  <= holdDataNext;
            holdFull  <= holdFullNext;
            shiftReg  <= shiftNext;
            bitCnt    <= bitCntNext;
            sdo       <= force_break ? 1'b0 : lineNext;
            seror_irq <= xfer;
            // Built from the registered state, so it trails the condition by a cycle.
            seroc     <= (state == IDLE) && !holdFull;
        end
    end

    always_comb begin
        stateNext    = state;
        holdDataNext = holdData;
        holdFullNext = holdFull;
        shiftNext    = shiftReg;
        bitCntNext   = bitCnt;
        xfer         = 1'b0;

        case (state)
            IDLE: begin
                // An empty holding register means ticks are simply ignored.
                if (bit_tick && holdFull)
                    xfer = 1'b1;
            end
            SHIFT: begin
                if (bit_tick) begin
                    if (bitCnt == 4'd9) begin
                        // End of the stop bit: chain the next frame or go idle.
                        if (holdFull) begin
                            xfer = 1'b1;
                        end else begin
                            stateNext  = IDLE;
                            bitCntNext = 4'd0;
                        end
                    end else begin
                        shiftNext  = {1'b1, shiftReg[9:1]};
                        bitCntNext = bitCnt + 4'd1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        // The transfer uses the pre-edge held byte, so a write in the same cycle
        // is held for the following frame instead of being lost.
        if (xfer) begin
            shiftNext    = {1'b1, holdData, 1'b0};
            bitCntNext   = 4'd0;
            stateNext    = SHIFT;
            holdFullNext = 1'b0;
        end

        if (wr_serout) begin
            holdDataNext = din;
            holdFullNext = 1'b1;
        end

        lineBit = (stateNext == SHIFT) ? shiftNext[0] : 1'b1;

`ifdef SEROUT_TWO_TONE_EN
        if (two_tone)
            lineNext = lineBit ? tone1 : tone2;
        else
            lineNext = lineBit;
`else
        lineNext = lineBit;
`endif
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serout_shifter.sv
// Directed bench for serout_shifter. A frame-position model runs alongside the
// DUT and is compared against it on every cycle; the directed scenarios also pin
// hand-computed bit streams and IRQ counts.
module tb_serout_shifter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_serout = 1'b0;
    logic [7:0] din = 8'h00;
    logic       bit_tick = 1'b0;
    logic       force_break = 1'b0;
    logic       tone1 = 1'b1;
    logic       tone2 = 1'b0;
    logic       two_tone = 1'b0;
    logic       sdo, seror_irq, seroc, busy;

    int nChecks = 0;
    int nFails  = 0;
    int irqCnt  = 0;
    bit chkEn   = 1'b0;

    serout_shifter dut (
        .clk(clk), .reset(reset), .wr_serout(wr_serout), .din(din),
        .bit_tick(bit_tick), .force_break(force_break),
`ifdef SEROUT_TWO_TONE_EN
        .tone1(tone1), .tone2(tone2), .two_tone(two_tone),
`endif
        .sdo(sdo), .seror_irq(seror_irq), .seroc(seroc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic act, logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic checkInt(string nm, int act, int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- model: frame position -1 (idle) or 0..9 ----------------
    logic [7:0] mHeld = 8'h00;
    bit         mHeldV = 1'b0;
    logic [7:0] mByte = 8'h00;
    int         mPos = -1;
    logic       eSdo = 1'b1, eIrq = 1'b0, eSeroc = 1'b1, eBusy = 1'b0;

    function automatic logic frameBit(logic [7:0] b, int p);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    always @(posedge clk) begin : model
        logic ln;
        if (reset) begin
            mHeld = 8'h00; mHeldV = 1'b0; mPos = -1;
            eSdo = 1'b1; eIrq = 1'b0; eSeroc = 1'b1; eBusy = 1'b0;
        end else begin
            eSeroc = (mPos < 0) && !mHeldV;
            eIrq = 1'b0;
            if (bit_tick) begin
                if (mPos >= 0 && mPos < 9) mPos++;
                else if (mHeldV) begin
                    mByte = mHeld; mPos = 0; mHeldV = 1'b0; eIrq = 1'b1;
                end else mPos = -1;
            end
            if (wr_serout) begin mHeld = din; mHeldV = 1'b1; end
            eBusy = (mPos >= 0);
            ln = (mPos < 0) ? 1'b1 : frameBit(mByte, mPos);
`ifdef SEROUT_TWO_TONE_EN
            if (two_tone) ln = ln ? tone1 : tone2;
`endif
            eSdo = force_break ? 1'b0 : ln;
        end
    end

    always @(negedge clk) begin
        if (seror_irq === 1'b1) irqCnt++;
        if (chkEn) begin
            check("cmp_sdo", sdo, eSdo);
            check("cmp_irq", seror_irq, eIrq);
            check("cmp_seroc", seroc, eSeroc);
            check("cmp_busy", busy, eBusy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic writeByte(logic [7:0] d);
        wr_serout = 1'b1; din = d;
        cyc(1);
        wr_serout = 1'b0;
    endtask

    // n ticks 16 cycles apart; bits[i] is sdo sampled mid-period after tick i.
    task automatic sendStream(int n, int brkIdx, int wrIdx, logic [7:0] wrData,
                              output logic [0:19] bits);
        bits = '1;
        for (int i = 0; i < n; i++) begin
            bit_tick = 1'b1;
            cyc(1);
            bit_tick = 1'b0;
            if (i == brkIdx) force_break = 1'b1;
            if (i == wrIdx) begin
                wr_serout = 1'b1; din = wrData;
                cyc(1);
                wr_serout = 1'b0;
                cyc(6);
            end else cyc(7);
            bits[i] = sdo;
            if (i == brkIdx) begin
                force_break = 1'b0;
                cyc(2);
                check("brk_resume", sdo, 1'b1);
                cyc(6);
            end else cyc(8);
        end
    endtask

    task automatic expectStream(string nm, int n, logic [0:19] got, logic [0:19] exp);
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
    endtask

    // Final tick that closes the stop bit; the line must return to idle.
    task automatic endTick(logic idleLevel);
        bit_tick = 1'b1;
        cyc(1);
        bit_tick = 1'b0;
        cyc(2);
        check("end_sdo", sdo, idleLevel);
        check("end_busy", busy, 1'b0);
        check("end_seroc", seroc, 1'b1);
        cyc(4);
    endtask

    initial begin
        logic [0:19] got;

        // Reset values
        cyc(3);
        check("rst_sdo", sdo, 1'b1);
        check("rst_seroc", seroc, 1'b1);
        check("rst_irq", seror_irq, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        chkEn = 1'b1;
        cyc(3);

        // 0xA5: single frame, seroc 1 -> 0 -> 1
        irqCnt = 0;
        check("a5_seroc_pre", seroc, 1'b1);
        writeByte(8'hA5);
        cyc(2);
        check("a5_seroc_held", seroc, 1'b0);
        sendStream(10, -1, -1, 8'h00, got);
        expectStream("a5", 10, got, 20'b0101001011_0000000000);
        endTick(1'b1);
        checkInt("a5_irqs", irqCnt, 1);

        // 0x55 then 0x0F written mid-frame: back-to-back frames
        irqCnt = 0;
        writeByte(8'h55);
        sendStream(20, -1, 0, 8'h0F, got);
        expectStream("b2b", 20, got, 20'b0101010101_0111100001);
        endTick(1'b1);
        checkInt("b2b_irqs", irqCnt, 2);

        // Overwrite before the first tick: only 0x22 goes out
        irqCnt = 0;
        writeByte(8'h11);
        writeByte(8'h22);
        sendStream(10, -1, -1, 8'h00, got);
        expectStream("ovw", 10, got, 20'b0010001001_0000000000);
        endTick(1'b1);
        checkInt("ovw_irqs", irqCnt, 1);

        // Write and tick together while idle and empty: no bypass
        irqCnt = 0;
        wr_serout = 1'b1; din = 8'h81; bit_tick = 1'b1;
        cyc(1);
        wr_serout = 1'b0; bit_tick = 1'b0;
        cyc(2);
        check("nobypass_busy", busy, 1'b0);
        check("nobypass_sdo", sdo, 1'b1);
        sendStream(10, -1, -1, 8'h00, got);
        expectStream("nobyp", 10, got, 20'b0100000011_0000000000);
        endTick(1'b1);
        checkInt("nobyp_irqs", irqCnt, 1);

        // Break during D3 of 0xFF
        irqCnt = 0;
        writeByte(8'hFF);
        sendStream(10, 4, -1, 8'h00, got);
        expectStream("brk", 10, got, 20'b0111011111_0000000000);
        endTick(1'b1);
        checkInt("brk_irqs", irqCnt, 1);

        // Reset during D4 of 0x3C, with a write and tick in the same cycle
        irqCnt = 0;
        writeByte(8'h3C);
        sendStream(6, -1, -1, 8'h00, got);
        expectStream("rstmid", 6, got, 20'b0001110000_0000000000);
        reset = 1'b1; wr_serout = 1'b1; din = 8'h99; bit_tick = 1'b1;
        cyc(1);
        reset = 1'b0; wr_serout = 1'b0; bit_tick = 1'b0;
        check("rstmid_sdo", sdo, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_seroc", seroc, 1'b1);
        sendStream(3, -1, -1, 8'h00, got);
        expectStream("rstafter", 3, got, 20'b1110000000_0000000000);
        checkInt("rstmid_irqs", irqCnt, 1);

`ifdef SEROUT_TWO_TONE_EN
        // Two-tone with inverted tones, so every level differs from the raw bit
        irqCnt = 0;
        two_tone = 1'b1; tone1 = 1'b0; tone2 = 1'b1;
        cyc(2);
        writeByte(8'h01);
        sendStream(10, -1, -1, 8'h00, got);
        expectStream("tone", 10, got, 20'b1011111110_0000000000);
        endTick(1'b0);
        checkInt("tone_irqs", irqCnt, 1);
        two_tone = 1'b0; tone1 = 1'b1; tone2 = 1'b0;
        cyc(2);
`endif

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
